// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// FSM encodings and the digit-count sanity check used at elaboration.
package bin2bcd_seq_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  // True when `digits` decimal digits can hold 2^width - 1.
  function automatic bit digits_ok(int width, int digits);
    longint unsigned lim;
    longint unsigned p;
    lim = (64'd1 << width) - 64'd1;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      if (p <= lim) p = p * 64'd10;
    end
    return p > lim;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
// Inputs are at most 9, so the 4-bit result never overflows.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Bcd is registered and only updated on completion, so displays never glitch.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Bin,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   Bcd
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  if (WIDTH < 4 || WIDTH > 32) begin : g_wchk
    $fatal(1, "bin2bcd_seq: WIDTH out of range 4..32");
  end
  if (!digits_ok(WIDTH, DIGITS)) begin : g_dchk
    $fatal(1, "bin2bcd_seq: DIGITS too small for WIDTH");
  end

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0]    scr;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt;
  logic             cap;
  logic             step;
  logic             load;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (scr[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (Start) state_n = CONV;
      CONV:    if (cnt == CW'(1)) state_n = LOAD;
      LOAD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == CONV) || (state == LOAD);
    cap  = (state == IDLE) && Start;
    step = (state == CONV);
    load = (state == LOAD);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sr   <= '0;
      scr  <= '0;
      cnt  <= '0;
      Bcd  <= '0;
      Done <= 1'b0;
    end else begin
      Done <= load;
      if (cap) begin
        sr  <= Bin;
        scr <= '0;
        cnt <= CW'(WIDTH);
      end else if (step) begin
        scr <= {adj[BW-2:0], sr[WIDTH-1]};
        sr  <= {sr[WIDTH-2:0], 1'b0};
        cnt <= cnt - CW'(1);
      end
      if (load) Bcd <= scr;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and table-driven bench for bin2bcd_seq (WIDTH=16, DIGITS=5).
// Latency is counted in rising edges from the edge that accepts Start.
module tb_bin2bcd_seq;

  localparam int LAT = 18;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] b;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[10];

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .Start (start),
    .Bin   (bin),
    .Busy  (busy),
    .Done  (done),
    .Bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] model(input int v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Waits for Done; cyc = edges from the accepting edge, 0 on timeout.
  task automatic wait_done(input bit drop, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      if (drop && i == 1) #1 start = 1'b0;
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic quiet(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk(name, seen, 0);
  endtask

  task automatic convert(input string name, input logic [15:0] v,
                         input logic [19:0] exp);
    int cyc;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    wait_done(1'b1, cyc);
    chk({name, "_lat"}, cyc, LAT);
    chk({name, "_bcd"}, bcd, exp);
    chk({name, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int cyc;
    int rbad;
    logic [15:0] r;
    tbl[0] = '{16'd0,     20'h00000};
    tbl[1] = '{16'd9,     20'h00009};
    tbl[2] = '{16'd10,    20'h00010};
    tbl[3] = '{16'd99,    20'h00099};
    tbl[4] = '{16'd100,   20'h00100};
    tbl[5] = '{16'd1234,  20'h01234};
    tbl[6] = '{16'd65535, 20'h65535};
    tbl[7] = '{16'd4096,  20'h04096};
    tbl[8] = '{16'd59999, 20'h59999};
    tbl[9] = '{16'd32768, 20'h32768};

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    #23 rst_n = 1'b1;

    quiet("idle_no_done", 10);
    chk("idle_bcd", bcd, 20'h0);
    chk("idle_busy", busy, 1'b0);

    foreach (tbl[i]) convert($sformatf("tbl%0d", i), tbl[i].b, tbl[i].exp);

    // Start held high: back-to-back conversions, Bin re-sampled each time.
    @(negedge clk);
    bin   = 16'd1234;
    start = 1'b1;
    wait_done(1'b0, cyc);
    chk("b2b1_lat", cyc, LAT);
    chk("b2b1_bcd", bcd, 20'h01234);
    bin = 16'd65535;
    wait_done(1'b0, cyc);
    start = 1'b0;
    chk("b2b2_gap", cyc, LAT);
    chk("b2b2_bcd", bcd, 20'h65535);
    quiet("b2b_stop", 25);

    // Start pulses during Busy are dropped.
    @(negedge clk);
    bin   = 16'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ign_busy", busy, 1'b1);
      bin   = 16'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    for (int i = 0; i < 30 && cyc == 0; i++) begin
      @(negedge clk);
      if (done) cyc = 1;
    end
    chk("ign_done", cyc, 1);
    chk("ign_bcd", bcd, 20'h00009);
    quiet("ign_no_second", 25);

    // Reset mid-conversion aborts without Done.
    @(negedge clk);
    bin   = 16'd500;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_bcd", bcd, 20'h0);
    chk("abort_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet("abort_no_done", 25);
    chk("abort_hold", bcd, 20'h0);
    convert("after_rst", 16'd42, 20'h00042);

    // Random sweep against a decimal model.
    rbad = bad;
    for (int n = 0; n < 2000; n++) begin
      r = 16'($urandom_range(0, 65535));
      convert($sformatf("rnd_%0d", r), r, model(int'(r)));
      for (int d = 0; d < 5; d++) chk("rnd_digit", 32'(bcd[4*d +: 4] <= 4'd9), 1);
      if (bad - rbad > 20) break;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that sits directly upstream of the per-digit 7-segment decoders on the DE2-115 display path. It accepts an unsigned binary value on a start strobe and, after a fixed latency, presents a registered packed BCD word. Each 4-bit digit field of that word drives one hex-to-segment decoder instance. The output holds steady between conversions, so the display never shows intermediate values.

## Interface
- WIDTH, 16, bit width of the binary input; legal range 4..32.
- DIGITS, 5, number of BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH − 1 (checked at elaboration, fatal if violated).
- Clk  in  1  clock; all state changes on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  conversion request; sampled only while idle.
- Bin  in  WIDTH  unsigned binary operand; sampled on the same edge that accepts Start.
- Busy  out  1  high while a conversion is in progress (states CONV and LOAD).
- Done  out  1  one-cycle pulse; Bcd is valid and updated in this cycle.
- Bcd  out  4*DIGITS  packed BCD result; Bcd[3:0] is the units digit, and Bcd[4*DIGITS-1:4*DIGITS-4] is the most significant digit.

## Operation
- FSM has three states: IDLE, CONV, LOAD.
- Reset: FSM enters IDLE; Bcd = 0, Done = 0, Busy = 0; internal shift register, scratch BCD register and bit counter all cleared.
- IDLE with Start = 1:
  - Capture Bin into the shift register.
  - Clear the scratch BCD register.
  - Set the counter to WIDTH.
  - Go to CONV.
- CONV, each cycle:
  - Every scratch digit ≥ 5 has 3 added (4-bit result, no carry out by construction).
  - The scratch register then shifts left 1, taking in the shift-register MSB.
  - The shift register shifts left 1.
  - The counter decrements.
  - When the counter reaches 1 on this edge (last iteration), go to LOAD.
- LOAD:
  - Bcd ← scratch register.
  - Done ← 1 for exactly one cycle.
  - Go to IDLE.
- Start while Busy is ignored and not queued. Bin changes while Busy have no effect.
- Start high in the same cycle as Done (FSM already in IDLE) is accepted normally.
- Start held high continuously produces back-to-back conversions, each re-sampling Bin.
- Bcd changes only on the LOAD edge and on reset.
- Reset asserted mid-conversion aborts immediately. Bcd clears to 0 and no Done is produced.

## Timing
- Start accepted at edge k; CONV iterations on edges k+1 … k+WIDTH; LOAD executes at edge k+WIDTH+1.
- Done and the new Bcd are visible in the cycle following edge k+WIDTH+1. Latency is WIDTH+2 cycles from Start sample (18 for WIDTH = 16).
- Busy is high from the cycle after edge k until the cycle after the LOAD edge, where it is low (the same cycle Done is high).
- Maximum throughput is one conversion per WIDTH+2 cycles.
- All outputs are registered or decoded only from state; no combinational path from inputs to outputs.

## Structure
- Shared include/package holds:
  - FSM state encodings (IDLE, CONV, LOAD as 2-bit localparams).
  - The elaboration check for the DIGITS/WIDTH relationship.
- Sub-module bcd_add3: 4-bit combinational "if ≥ 5 add 3" cell, instantiated DIGITS times in a generate loop.
- Counter width is $clog2(WIDTH+1).

## Test plan
- Reset then idle, Start never asserted -> Bcd = 20'h00000, Busy = 0, Done never asserts.
- Bin = 0, Start pulse -> Done 18 cycles after Start sample; Bcd = 20'h00000.
- Bin = 16'd1234, then Bin = 16'd65535 (Start held high for back-to-back) -> first Done with Bcd = 20'h01234; next Done exactly 18 cycles later with Bcd = 20'h65535.
- Bin = 16'd9 accepted; Start pulses with Bin = 16'd7 during Busy -> single Done, Bcd = 20'h00009; no second Done.
- Start with Bin = 16'd500; Rst_n low at cycle 8 of the conversion -> Bcd = 0, Busy = 0 immediately; no Done. After release, Bin = 16'd42 -> Bcd = 20'h00042.
- Random sweep, 2000 values plus 0, 9, 10, 99, 100, 65535 -> each Bcd digit equals the decimal digit of Bin, and every digit is ≤ 9.
